// File: rtl/sprite_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer_if
//  Purpose  : Bundles the sprite renderer's request, sprite-ROM and LCD pixel
//             handshake signals. master = renderer side, slave = environment.
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_renderer_if #(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
);
    localparam int c_addr_w = 4 + $clog2(SPRITE_W * SPRITE_H);

    logic                start;
    logic [7:0]          xSprite;
    logic [8:0]          ySprite;
    logic [3:0]          spriteId;
    logic [c_addr_w-1:0] romAddress;
    logic [15:0]         romData;
    logic [7:0]          pixelX;
    logic [8:0]          pixelY;
    logic [15:0]         pixelData;
    logic                pixelWrite;
    logic                pixelReady;
    logic                busy;
    logic                done;

    modport master (
        input  start, xSprite, ySprite, spriteId, romData, pixelReady,
        output romAddress, pixelX, pixelY, pixelData, pixelWrite, busy, done
    );

    modport slave (
        output start, xSprite, ySprite, spriteId, romData, pixelReady,
        input  romAddress, pixelX, pixelY, pixelData, pixelWrite, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer
//  Purpose  : Walks one sprite bitmap through a synchronous ROM and emits a
//             pixel write for every opaque, on-screen pixel toward the LCD.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_renderer #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter int          LCD_W       = 240,
    parameter int          LCD_H       = 320
) (
    input  wire logic            clock,
    input  wire logic            reset,
    sprite_renderer_if.master    bus
);

    localparam int c_pix_n  = SPRITE_W * SPRITE_H;
    localparam int c_addr_w = 4 + $clog2(c_pix_n);
    localparam int c_col_w  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_row_w  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(SPRITE_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(SPRITE_H - 1);
    localparam logic [8:0]         c_lcd_w    = 9'(LCD_W);
    localparam logic [9:0]         c_lcd_h    = 10'(LCD_H);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_ROM = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched draw request
    logic [7:0]          r_x;
    logic [8:0]          r_y;
    logic [3:0]          r_id;

    // Bitmap walk position
    logic [c_col_w-1:0]  r_col;
    logic [c_row_w-1:0]  r_row;

    // Registered outputs
    logic [c_addr_w-1:0] r_rom_addr;
    logic [7:0]          r_pix_x;
    logic [8:0]          r_pix_y;
    logic [15:0]         r_pix_data;
    logic                r_busy;
    logic                r_done;

    // Per-pixel decisions
    logic [8:0]          w_px;
    logic [9:0]          w_py;
    logic                w_visible;
    logic                w_last_col;
    logic                w_last;
    logic                w_accept;
    logic                w_advance;
    logic [c_col_w-1:0]  w_col_nxt;
    logic [c_row_w-1:0]  w_row_nxt;
    logic [c_addr_w-1:0] w_next_addr;

    // Linear ROM address of one bitmap cell: id*W*H + row*W + col.
    function automatic logic [c_addr_w-1:0] pix_addr(
        input logic [3:0]         id,
        input logic [c_row_w-1:0] row,
        input logic [c_col_w-1:0] col
    );
        return c_addr_w'(id) * c_addr_w'(c_pix_n)
             + c_addr_w'(row) * c_addr_w'(SPRITE_W)
             + c_addr_w'(col);
    endfunction

    // Screen coordinates are one bit wider than the LCD ports so that an
    // origin near the right/bottom edge cannot wrap back onto the screen.
    assign w_px      = {1'b0, r_x} + 9'(r_col);
    assign w_py      = {1'b0, r_y} + 10'(r_row);
    assign w_visible = (bus.romData != TRANSPARENT) && (w_px < c_lcd_w) && (w_py < c_lcd_h);

    assign w_last_col = (r_col == c_col_last);
    assign w_last     = w_last_col && (r_row == c_row_last);
    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_advance  = ((r_state == S_WAIT_ROM) && !w_visible)
                     || ((r_state == S_WRITE) && bus.pixelReady);

    assign w_col_nxt   = w_last_col ? '0 : r_col + c_col_w'(1);
    assign w_row_nxt   = w_last_col ? (w_last ? '0 : r_row + c_row_w'(1)) : r_row;
    assign w_next_addr = pix_addr(r_id, w_row_nxt, w_col_nxt);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (w_visible) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end
            end
            S_WRITE: begin
                if (bus.pixelReady) begin
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: request latch, bitmap walk, pixel capture and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_id       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_pix_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);

            if (w_accept) begin
                r_x        <= bus.xSprite;
                r_y        <= bus.ySprite;
                r_id       <= bus.spriteId;
                r_col      <= '0;
                r_row      <= '0;
                r_rom_addr <= pix_addr(bus.spriteId, c_row_w'(0), c_col_w'(0));
                r_busy     <= 1'b1;
            end

            // busy drops in the same edge that raises done
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end

            // Capture the pixel once; it stays frozen for the whole WRITE stall
            if ((r_state == S_WAIT_ROM) && w_visible) begin
                r_pix_x    <= w_px[7:0];
                r_pix_y    <= w_py[8:0];
                r_pix_data <= bus.romData;
            end

            if (w_advance) begin
                r_col      <= w_col_nxt;
                r_row      <= w_row_nxt;
                r_rom_addr <= w_next_addr;
            end
        end
    end

    assign bus.romAddress = r_rom_addr;
    assign bus.pixelX     = r_pix_x;
    assign bus.pixelY     = r_pix_y;
    assign bus.pixelData  = r_pix_data;
    assign bus.pixelWrite = (r_state == S_WRITE);
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_renderer
//  Purpose  : Self-checking bench for sprite_renderer with a behavioural
//             sprite model, synchronous ROM model and LCD backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_renderer;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sprite_renderer_if #(.SPRITE_W(32), .SPRITE_H(32)) bus ();

    sprite_renderer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous sprite ROM: data valid one cycle after the address
    logic [15:0] rom [0:16383];
    always @(posedge clock) bus.romData <= rom[bus.romAddress];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered list of pixels the LCD must receive
    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    pix_t exp_q[$];
    int   exp_opaque;
    int   exp_skip;

    function automatic void build_model(input int x, input int y, input int id);
        pix_t p;
        exp_q.delete();
        exp_opaque = 0;
        exp_skip   = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                int d;
                d = int'(rom[id * 1024 + r * 32 + c]);
                if (d != 'hF81F && (x + c) < 240 && (y + r) < 320) begin
                    p.x = x + c;
                    p.y = y + r;
                    p.d = d;
                    exp_q.push_back(p);
                    exp_opaque++;
                end else begin
                    exp_skip++;
                end
            end
        end
    endfunction

    function automatic logic [63:0] pack(input int x, input int y, input int d);
        return (64'(x) << 32) | (64'(y) << 16) | 64'(d & 'hFFFF);
    endfunction

    // mode 0: ready always high; 1: 5-cycle stall on 2nd write; 2: random stalls
    task automatic draw(input int x, input int y, input int id, input int mode,
                        input bit restart, input string name);
        int  stall_plan[$];
        int  idx         = 0;
        int  stall_ctr   = 0;
        int  t           = 0;
        int  stall_total = 0;
        bit  got_done    = 1'b0;

        build_model(x, y, id);
        for (int i = 0; i < exp_q.size(); i++) begin
            int s;
            s = (mode == 1) ? ((i == 1) ? 5 : 0)
              : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            stall_plan.push_back(s);
            stall_total += s;
        end

        @(posedge clock); #1;
        bus.xSprite    = 8'(x);
        bus.ySprite    = 9'(y);
        bus.spriteId   = 4'(id);
        bus.start      = 1'b1;
        bus.pixelReady = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        t = 1;
        chk({name, " busy after start"}, 64'(bus.busy), 64'd1);
        chk({name, " first addr"}, 64'(bus.romAddress), 64'(id * 1024));

        while (!got_done && t < 20000) begin
            if (bus.done) begin
                got_done = 1'b1;
                chk({name, " busy with done"}, 64'(bus.busy), 64'd0);
            end else begin
                if (bus.pixelWrite) begin
                    if (idx >= exp_q.size()) begin
                        chk({name, " extra write"}, 64'(idx + 1), 64'(exp_q.size()));
                        bus.pixelReady = 1'b1;
                        idx++;
                    end else begin
                        chk({name, " pixel"},
                            (64'(bus.pixelX) << 32) | (64'(bus.pixelY) << 16) | 64'(bus.pixelData),
                            pack(exp_q[idx].x, exp_q[idx].y, exp_q[idx].d));
                        if (stall_ctr < stall_plan[idx]) begin
                            bus.pixelReady = 1'b0;
                            stall_ctr++;
                        end else begin
                            bus.pixelReady = 1'b1;
                            idx++;
                            stall_ctr = 0;
                        end
                    end
                end else begin
                    bus.pixelReady = 1'($urandom_range(0, 1));
                end
                if (restart && t == 200) begin
                    bus.start   = 1'b1;
                    bus.xSprite = 8'd53;
                end
                if (restart && t == 201) begin
                    bus.start = 1'b0;
                end
                @(posedge clock); #1;
                t++;
            end
        end

        bus.start = 1'b0;
        chk({name, " done seen"}, 64'(got_done), 64'd1);
        chk({name, " write count"}, 64'(idx), 64'(exp_q.size()));
        chk({name, " cycles"}, 64'(t), 64'(2 + 3 * exp_opaque + 2 * exp_skip + stall_total));

        bus.pixelReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            chk({name, " idle after done"},
                {61'd0, bus.done, bus.busy, bus.pixelWrite}, 64'd0);
        end
    endtask

    initial begin
        int wait_ctr;

        for (int a = 0; a < 16384; a++) begin
            int id;
            int r;
            int c;
            id = a / 1024;
            r  = (a / 32) % 32;
            c  = a % 32;
            if (id == 0) begin
                rom[a] = 16'h07E0;
            end else if (id == 3) begin
                rom[a] = ((r + c) % 2 == 0) ? 16'hF81F : 16'hFFFF;
            end else begin
                rom[a] = ($urandom_range(0, 3) == 0) ? 16'hF81F : 16'($urandom);
            end
        end

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.xSprite    = '0;
        bus.ySprite    = '0;
        bus.spriteId   = '0;
        bus.pixelReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset addr", 64'(bus.romAddress), 64'd0);
        chk("reset pixel",
            (64'(bus.pixelX) << 32) | (64'(bus.pixelY) << 16) | 64'(bus.pixelData), 64'd0);
        chk("reset flags", {61'd0, bus.done, bus.busy, bus.pixelWrite}, 64'd0);
        reset = 1'b0;

        draw(95, 129, 0, 0, 1'b0, "opaque");
        draw(10, 20, 3, 0, 1'b0, "checker");
        draw(230, 310, 0, 0, 1'b0, "clip");
        draw(95, 129, 0, 1, 1'b0, "stall");
        draw(95, 129, 0, 0, 1'b1, "restart");

        // Reset while a write is pending
        @(posedge clock); #1;
        bus.xSprite  = 8'd40;
        bus.ySprite  = 9'd50;
        bus.spriteId = 4'd0;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_ctr  = 0;
        while (!bus.pixelWrite && wait_ctr < 100) begin
            @(posedge clock); #1;
            wait_ctr++;
        end
        chk("rst write reached", 64'(bus.pixelWrite), 64'd1);
        bus.pixelReady = 1'b0;
        reset          = 1'b1;
        @(posedge clock); #1;
        chk("rst mid-draw flags", {61'd0, bus.done, bus.busy, bus.pixelWrite}, 64'd0);
        reset          = 1'b0;
        bus.pixelReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            chk("rst stays idle", {61'd0, bus.done, bus.busy, bus.pixelWrite}, 64'd0);
        end
        draw(40, 50, 0, 0, 1'b0, "redraw");

        for (int n = 0; n < 3; n++) begin
            draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 400)),
                 int'($urandom_range(0, 15)), 2, 1'b0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_renderer.md
# sprite_renderer

Draws one sprite into the LT24 LCD pixel stream. It consumes the `xSprite`, `ySprite` and `spriteId` triple produced by the player-update logic. On a `start` pulse it latches the triple and walks the sprite bitmap row by row through a synchronous sprite ROM. It emits one pixel write per opaque, on-screen pixel over a valid/ready handshake toward the LCD driver. It sits between the game-state logic and the LT24 display interface, and is triggered once per frame per sprite.

## Interface
- `SPRITE_W`, 32: sprite width in pixels.
- `SPRITE_H`, 32: sprite height in pixels.
- `TRANSPARENT`, 16'hF81F: RGB565 key colour that is never written.
- `LCD_W`, 240: screen width, i.e. the x bound.
- `LCD_H`, 320: screen height, i.e. the y bound.

Ports:
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to draw. Sampled only in IDLE.
- `xSprite` in 8: sprite origin x (column of the top-left pixel).
- `ySprite` in 9: sprite origin y (row of the top-left pixel).
- `spriteId` in 4: bitmap index, 0-15.
- `romAddress` out 4+$clog2(SPRITE_W*SPRITE_H): sprite ROM address.
- `romData` in 16: RGB565 ROM output. Valid one cycle after the address.
- `pixelX` out 8: LCD x of the pending pixel.
- `pixelY` out 9: LCD y of the pending pixel.
- `pixelData` out 16: RGB565 colour of the pending pixel.
- `pixelWrite` out 1: pixel valid.
- `pixelReady` in 1: LCD driver accepts the pixel.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the sprite is complete.

## Operation
- **State machine:** IDLE -> FETCH -> WAIT_ROM -> (WRITE | skip) -> FETCH ... -> DONE -> IDLE.
- **IDLE:**
  - On `start`=1: latch x/y/id, clear `col` and `row`, go to FETCH.
  - `start` in any other state is ignored; it is not queued.
- **FETCH:** drive `romAddress = id*SPRITE_W*SPRITE_H + row*SPRITE_W + col`, then go to WAIT_ROM.
- **WAIT_ROM:**
  - Register `romData`.
  - Compute `px = x+col` and `py = y+row`, each one bit wider than the output so overflow is detected.
  - If the colour equals `TRANSPARENT`, or `px >= LCD_W`, or `py >= LCD_H`: skip the pixel and advance.
  - Otherwise go to WRITE.
- **WRITE:**
  - Assert `pixelWrite` with `pixelX`, `pixelY` and `pixelData` held stable.
  - The pixel is transferred on the cycle where `pixelWrite && pixelReady`. Then advance.
  - While `pixelReady`=0, stay in WRITE with all outputs unchanged.
- **Advance:**
  - `col` increments. At `SPRITE_W-1` it wraps to 0 and `row` increments.
  - After the last pixel (`col=SPRITE_W-1`, `row=SPRITE_H-1`) go to DONE. Otherwise go to FETCH.
- **DONE:** pulse `done` for 1 cycle, deassert `busy`, return to IDLE.
- **Reset:** at any point, including mid-sprite, returns to IDLE next edge. A partially drawn sprite is abandoned and no further write is issued.
- **Reset values:**
  - state IDLE.
  - `romAddress` 0.
  - `pixelX` 0, `pixelY` 0, `pixelData` 0.
  - `pixelWrite` 0, `busy` 0, `done` 0.
  - `col` 0, `row` 0.
- **Input stability:** `xSprite`, `ySprite` and `spriteId` may change while `busy`. The latched copies are used for the whole draw.

## Timing
- **`start` response:** `start` sampled high at edge N gives `busy`=1 and the first `romAddress` at N+1.
- **Per-pixel cost:**
  - Opaque pixel with `pixelReady` tied high: 3 cycles (FETCH, WAIT_ROM, WRITE).
  - Skipped pixel: 2 cycles.
- **Full sprite:**
  - With all pixels opaque and `pixelReady`=1: 3*W*H cycles from the first FETCH to DONE, then `done` 1 cycle later.
  - At the default 32x32: 3072 cycles plus 2.
- **`pixelWrite`:** never high outside WRITE. It is never high in two consecutive cycles for different pixels, because at least one FETCH cycle separates them.
- **`done` and `busy`:** `done` and `busy` are never high in the same cycle. `start` can be accepted in the cycle after `done`.

## Test plan
- **Opaque sprite:**
  - Stimulus: `reset`, then `start` with x=95, y=129, id=0; ROM id 0 all 16'h07E0; `pixelReady`=1.
  - Response: exactly 1024 writes. First is (95,129), last is (126,160), all data 07E0. `done` arrives 3074 cycles after `start`.
- **Transparency:**
  - Stimulus: id=3 with a checkerboard of 16'hF81F and 16'hFFFF.
  - Response: exactly 512 writes, all data FFFF, at the cells with (col+row) odd, or even per the ROM pattern.
- **Clipping:**
  - Stimulus: x=230, y=310, opaque sprite.
  - Response: only pixels with px<240 and py<320 are written, i.e. 10x10=100 writes. No write has x>239 or y>319.
- **Backpressure:**
  - Stimulus: `pixelReady` low for 5 cycles on the 2nd pixel.
  - Response: `pixelWrite`, `pixelX`, `pixelY` and `pixelData` are held constant for the whole stall. The total write count is unchanged, and the cycle count grows by 5.
- **Start while busy and latch stability:**
  - Stimulus: pulse `start` again mid-draw, and change `xSprite` to 53.
  - Response: the second `start` is ignored. All writes use x=95, and exactly one `done`.
- **Reset mid-draw:**
  - Stimulus: assert `reset` during WRITE.
  - Response: next cycle `pixelWrite`=0, `busy`=0 and `done`=0. A fresh `start` redraws from (x,y) with `col`=`row`=0.
